// File: rtl/sysbus_memory_if.sv
// SysBus handshake bundle between the core (master) and the memory slave.
// Carries the shared bus value, the control-FSM strobes and the read-return path.
interface sysbus_memory_if #(
  parameter int DW = 16
);
  logic [DW-1:0] SysBusIn;
  logic          ALE;
  logic          nME;
  logic          nOE;
  logic          nWE;
  logic          ENB;
  logic [DW-1:0] SysBusOut;
  logic          SysBusDrive;

  modport master (
    output SysBusIn, ALE, nME, nOE, nWE, ENB,
    input  SysBusOut, SysBusDrive
  );

  modport slave (
    input  SysBusIn, ALE, nME, nOE, nWE, ENB,
    output SysBusOut, SysBusDrive
  );
endinterface

// File: rtl/sysbus_memory.sv
// Word-addressed SysBus memory slave: latches addresses, serves reads with a
// registered return path, commits one write per nWE falling strobe, protects
// the boot region and records sticky protocol / write-protect errors.
module sysbus_memory #(
  parameter int DW        = 16,
  parameter int AW        = 10,
  parameter int ROM_WORDS = 64
) (
  input  logic          Clock,
  input  logic          nReset,
  sysbus_memory_if.slave bus,
  output logic [DW-1:0] LatchedAddr,
  output logic          BusErr,
  output logic          WrProtErr
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] ROM_LIMIT = AW'(ROM_WORDS);

  // Debug-only decode of the bus access in progress; never gates behaviour.
  typedef enum logic [1:0] {
    ACC_OFF  = 2'd0,
    ACC_ADDR = 2'd1,
    ACC_RD   = 2'd2,
    ACC_WR   = 2'd3
  } acc_state_e;

  // Tracks whether the current nWE-low strobe has already been consumed.
  typedef enum logic {
    WS_ARMED     = 1'b0,
    WS_COMMITTED = 1'b1
  } ws_state_e;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          drive_q, drive_d;
  logic          nwe_prev_q, nwe_prev_d;
  logic          bus_err_q, bus_err_d;
  logic          wrprot_q, wrprot_d;
  acc_state_e    acc_q, acc_d;
  ws_state_e     ws_q, ws_d;

  logic          read_s;
  logic          write_s;
  logic          conflict_s;
  logic [AW-1:0] index_s;
  logic          rom_hit_s;
  logic          commit_s;
  logic          mem_we_s;

  assign read_s     = ~bus.nME & ~bus.nOE &  bus.nWE;
  assign write_s    = ~bus.nME &  bus.nOE & ~bus.nWE;
  assign conflict_s = ~bus.nME & ~bus.nOE & ~bus.nWE;
  assign index_s    = addr_q[AW-1:0];
  assign rom_hit_s  = (index_s < ROM_LIMIT);
  assign commit_s   = write_s & nwe_prev_q;
  // A strobe landing on a reset edge must not reach the array.
  assign mem_we_s   = nReset & commit_s & ~rom_hit_s;

  // Next-state computation for all datapath registers, flags and both FSMs.
  always_comb begin
    addr_d     = addr_q;
    rd_d       = rd_q;
    drive_d    = 1'b0;
    nwe_prev_d = bus.nWE;
    bus_err_d  = bus_err_q;
    wrprot_d   = wrprot_q;
    acc_d      = acc_q;
    ws_d       = ws_q;

    if (bus.ALE) begin
      addr_d = bus.SysBusIn;
    end else begin
      addr_d = addr_q;
    end

    // Array read sees the pre-write contents, giving read-before-write.
    if (read_s) begin
      rd_d = mem[index_s];
    end else begin
      rd_d = rd_q;
    end

    drive_d = bus.ENB & read_s;

    if (commit_s & rom_hit_s) begin
      wrprot_d = 1'b1;
    end else begin
      wrprot_d = wrprot_q;
    end

    if (conflict_s | (bus.ALE & ~bus.nME) | (bus.ENB & bus.nOE & ~bus.nME)) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_q;
    end

    case (acc_q)
      ACC_OFF: begin
        if (bus.ALE) acc_d = ACC_ADDR;
        else         acc_d = ACC_OFF;
      end
      ACC_ADDR: begin
        if (read_s)       acc_d = ACC_RD;
        else if (write_s) acc_d = ACC_WR;
        else              acc_d = ACC_ADDR;
      end
      ACC_RD, ACC_WR: begin
        if (bus.ALE)      acc_d = ACC_ADDR;
        else if (bus.nME) acc_d = ACC_OFF;
        else              acc_d = acc_q;
      end
      default: acc_d = ACC_OFF;
    endcase

    case (ws_q)
      WS_ARMED: begin
        if (commit_s) ws_d = WS_COMMITTED;
        else          ws_d = WS_ARMED;
      end
      WS_COMMITTED: begin
        if (bus.nWE) ws_d = WS_ARMED;
        else         ws_d = WS_COMMITTED;
      end
      default: ws_d = WS_ARMED;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      addr_q     <= '0;
      rd_q       <= '0;
      drive_q    <= 1'b0;
      nwe_prev_q <= 1'b1;
      bus_err_q  <= 1'b0;
      wrprot_q   <= 1'b0;
      acc_q      <= ACC_OFF;
      ws_q       <= WS_ARMED;
    end else begin
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      drive_q    <= drive_d;
      nwe_prev_q <= nwe_prev_d;
      bus_err_q  <= bus_err_d;
      wrprot_q   <= wrprot_d;
      acc_q      <= acc_d;
      ws_q       <= ws_d;
    end
  end

  // RAM array; contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem[index_s] <= bus.SysBusIn;
    end
  end

  assign bus.SysBusOut   = rd_q;
  assign bus.SysBusDrive = drive_q;
  assign LatchedAddr     = addr_q;
  assign BusErr          = bus_err_q;
  assign WrProtErr       = wrprot_q;

endmodule

// File: tb/tb_sysbus_memory.sv
// Directed bench for sysbus_memory with a per-edge behavioural model and a
// few hand-computed literal expectations.
module tb_sysbus_memory;

  logic        clk;
  logic        nreset;
  logic [15:0] latched_addr;
  logic        bus_err;
  logic        wrprot_err;

  sysbus_memory_if #(.DW(16)) bus ();

  sysbus_memory #(.DW(16), .AW(10), .ROM_WORDS(64)) dut (
    .Clock      (clk),
    .nReset     (nreset),
    .bus        (bus),
    .LatchedAddr(latched_addr),
    .BusErr     (bus_err),
    .WrProtErr  (wrprot_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_mem [1024];
  bit          m_known [1024];
  logic [15:0] m_addr;
  logic [15:0] m_rd;
  bit          m_rd_known;
  bit          m_drive;
  bit          m_prev;
  bit          m_berr;
  bit          m_wperr;
  bit          m_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: apply the bus rules to the values sampled at each rising edge,
  // then compare every observable output shortly after the edge.
  always @(posedge clk) begin
    bit rdc, wrc, conf;
    int idx;
    if (!nreset) begin
      m_addr = 16'h0000; m_rd = 16'h0000; m_rd_known = 1'b1;
      m_drive = 1'b0; m_prev = 1'b1; m_berr = 1'b0; m_wperr = 1'b0;
      m_valid = 1'b1;
    end else begin
      rdc  = !bus.nME && !bus.nOE &&  bus.nWE;
      wrc  = !bus.nME &&  bus.nOE && !bus.nWE;
      conf = !bus.nME && !bus.nOE && !bus.nWE;
      idx  = int'(m_addr) % 1024;
      if (rdc) begin
        m_rd = m_mem[idx];
        m_rd_known = m_known[idx];
      end
      if (wrc && m_prev) begin
        if (idx < 64) m_wperr = 1'b1;
        else begin
          m_mem[idx] = bus.SysBusIn;
          m_known[idx] = 1'b1;
        end
      end
      if (conf || (bus.ALE && !bus.nME) || (bus.ENB && bus.nOE && !bus.nME))
        m_berr = 1'b1;
      m_drive = bus.ENB && rdc;
      m_prev = bus.nWE;
      if (bus.ALE) m_addr = bus.SysBusIn;
    end
    #1;
    if (m_valid) begin
      if (m_rd_known) chk("model_SysBusOut", bus.SysBusOut, m_rd);
      chk("model_SysBusDrive", {15'd0, bus.SysBusDrive}, {15'd0, m_drive});
      chk("model_LatchedAddr", latched_addr, m_addr);
      chk("model_BusErr", {15'd0, bus_err}, {15'd0, m_berr});
      chk("model_WrProtErr", {15'd0, wrprot_err}, {15'd0, m_wperr});
    end
  end

  // One bus cycle: drive on the falling edge, return at the next rising edge.
  task automatic step(input bit rst, input bit ale, input bit nme, input bit noe,
                      input bit nwe, input bit enb, input logic [15:0] din);
    @(negedge clk);
    nreset = rst; bus.ALE = ale; bus.nME = nme; bus.nOE = noe;
    bus.nWE = nwe; bus.ENB = enb; bus.SysBusIn = din;
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic fetch(input logic [15:0] a);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic stw(input logic [15:0] a, input logic [15:0] d0, input logic [15:0] d1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d1);
    idle();
  endtask

  initial begin
    nreset = 1'b0; bus.ALE = 1'b0; bus.nME = 1'b1; bus.nOE = 1'b1;
    bus.nWE = 1'b1; bus.ENB = 1'b0; bus.SysBusIn = 16'h0000;
    @(posedge clk);
    idle();
    // Preload through the bus, then reset twice: RAM must survive.
    stw(16'h0040, 16'hBEEF, 16'hBEEF);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    #2;
    chk("rst_SysBusOut", bus.SysBusOut, 16'h0000);
    chk("rst_Drive", {15'd0, bus.SysBusDrive}, 16'h0000);
    chk("rst_LatchedAddr", latched_addr, 16'h0000);
    chk("rst_BusErr", {15'd0, bus_err}, 16'h0000);
    chk("rst_WrProtErr", {15'd0, wrprot_err}, 16'h0000);

    // Zero-wait fetch
    fetch(16'h0040);
    #2;
    chk("fetch_data", bus.SysBusOut, 16'hBEEF);
    chk("fetch_drive", {15'd0, bus.SysBusDrive}, 16'h0001);
    idle();
    #2;
    chk("drive_one_cycle", {15'd0, bus.SysBusDrive}, 16'h0000);
    chk("data_holds", bus.SysBusOut, 16'hBEEF);

    // Held nWE commits once; later data change ignored
    stw(16'h0100, 16'h1234, 16'h5678);
    fetch(16'h0100);
    #2;
    chk("single_commit", bus.SysBusOut, 16'h1234);

    // Write into protected boot region
    stw(16'h0010, 16'hFFFF, 16'hFFFF);
    #2;
    chk("wrprot_set", {15'd0, wrprot_err}, 16'h0001);
    fetch(16'h0010);
    #2;
    checks++;
    if (bus.SysBusOut === 16'hFFFF) begin
      errors++;
      $display("FAIL rom_unchanged actual=%h required=not_ffff", bus.SysBusOut);
    end

    // Aliasing modulo DEPTH
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0500);
    #2;
    chk("latched_0500", latched_addr, 16'h0500);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA5A5);
    idle();
    fetch(16'h0100);
    #2;
    chk("alias_read", bus.SysBusOut, 16'hA5A5);

    // Strobe conflict: error, no write, sticky
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hDEAD);
    #2;
    chk("conflict_berr", {15'd0, bus_err}, 16'h0001);
    for (int i = 0; i < 10; i++) idle();
    #2;
    chk("berr_sticky", {15'd0, bus_err}, 16'h0001);
    chk("wrprot_sticky", {15'd0, wrprot_err}, 16'h0001);
    fetch(16'h0100);
    #2;
    chk("conflict_nowrite", bus.SysBusOut, 16'hA5A5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    #2;
    chk("berr_cleared", {15'd0, bus_err}, 16'h0000);
    chk("wrprot_cleared", {15'd0, wrprot_err}, 16'h0000);

    // Reset on the would-be commit edge
    stw(16'h0200, 16'h0000, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0200);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h9999);
    #2;
    chk("rstw_LatchedAddr", latched_addr, 16'h0000);
    chk("rstw_SysBusOut", bus.SysBusOut, 16'h0000);
    chk("rstw_BusErr", {15'd0, bus_err}, 16'h0000);
    idle();
    fetch(16'h0200);
    #2;
    chk("rstw_nocommit", bus.SysBusOut, 16'h0000);

    // Back-to-back fetches, no idle between
    fetch(16'h0040);
    #2;
    chk("b2b_first", bus.SysBusOut, 16'hBEEF);
    fetch(16'h0500);
    #2;
    chk("b2b_second", bus.SysBusOut, 16'hA5A5);
    chk("b2b_drive", {15'd0, bus.SysBusDrive}, 16'h0001);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
